// File: rtl/fetch_pkg.sv
// Shared types and constants for the 9-bit CPU instruction fetch front end.
package fetch_pkg;
   localparam int PC_W   = 8;
   localparam int INST_W = 9;
   localparam logic [INST_W-1:0] HALT_INST = 9'h1FF;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } fetch_state_t;

   typedef struct packed {
      logic [INST_W-1:0] inst;
      logic [PC_W-1:0]   pc;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// DEPTH-entry synchronous FIFO of fetched {inst, pc} entries; clear beats push.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic                   clear,
   input  fetch_entry_t           din,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count,
   output fetch_entry_t           head
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   fetch_entry_t   mem [DEPTH];
   logic [AW-1:0]  rd_ptr;
   logic [AW-1:0]  wr_ptr;
   logic           do_push;
   logic           do_pop;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   // A push into a full queue is accepted only when the head leaves the same cycle.
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end
endmodule

// File: rtl/fetch_unit.sv
// Fetch front end: pc register, fetch FSM, redirect handling and the decode queue.
// Optional halt detection is enabled by defining FETCH_HALT_DETECT_EN.
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2
)
(
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   output logic [PC_W-1:0]   imem_pc,
   input  logic [INST_W-1:0] imem_inst,
   input  logic              redirect,
   input  logic [PC_W-1:0]   redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [INST_W-1:0] inst_out,
   output logic [PC_W-1:0]   inst_pc,
   output logic              busy,
   output logic              halted,
   output fetch_state_t      dbg_state
);
   localparam int CW = $clog2(DEPTH) + 1;

   fetch_state_t    state, state_n;
   logic [PC_W-1:0] pc, pc_n;
   logic            q_push, q_clear, q_full, q_empty, pop, fire, is_halt;
   logic [CW-1:0]   q_count;
   fetch_entry_t    q_head, q_din;

   // Decode handshake: inst_valid means the head entry is present; a transfer
   // completes on any edge where inst_valid && inst_ready, and the head is held
   // unchanged until then.
   assign inst_valid = !q_empty;
   assign pop        = inst_valid && inst_ready;
   assign fire       = (state == RUN) && (!q_full || pop);
   assign q_din      = '{inst: imem_inst, pc: pc};
   assign imem_pc    = pc;
   assign inst_out   = q_head.inst;
   assign inst_pc    = q_head.pc;
   assign busy       = (state == RUN) || (state == DRAIN);
   assign dbg_state  = state;

`ifdef FETCH_HALT_DETECT_EN
   assign is_halt = (imem_inst == HALT_INST);
   assign halted  = (state == HALT);
`else
   assign is_halt = 1'b0;
   assign halted  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         pc    <= '0;
      end else begin
         state <= state_n;
         pc    <= pc_n;
      end
   end

   always_comb begin
      state_n = state;
      pc_n    = pc;
      q_push  = 1'b0;
      q_clear = 1'b0;
      case (state)
         IDLE, HALT: begin
            if (start) begin
               state_n = RUN;
               pc_n    = '0;
               q_clear = 1'b1;
            end
         end
         RUN: begin
            if (redirect) begin
               pc_n    = redirect_pc;
               q_clear = 1'b1;
            end else if (fire) begin
               q_push = 1'b1;
               // The halt instruction is queued but pc parks on it.
               if (is_halt) state_n = DRAIN;
               else         pc_n    = pc + 1'b1;
            end
         end
         DRAIN: begin
            if (redirect) begin
               state_n = RUN;
               pc_n    = redirect_pc;
               q_clear = 1'b1;
            end else if (q_empty || (pop && q_count == CW'(1))) begin
               state_n = HALT;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (q_push),
      .pop   (pop),
      .clear (q_clear),
      .din   (q_din),
      .full  (q_full),
      .empty (q_empty),
      .count (q_count),
      .head  (q_head)
   );
endmodule
